// File: rtl/decode_uop_seq.sv
// ---------------------------------------------------------------------------
// decode_uop_seq: decode stage between fetch and rename.
//
// Each fetched instruction is statically decoded and expanded into one or two
// uops. A JAL/JALR whose rd is not x0 is split into "auipc rd, 4" followed by
// the jump with rd=x0. Every uop gets a sequential instruction id. Control
// uops are pushed to the branch queue. All uops are buffered in an
// OUT_DEPTH-entry FIFO toward rename.
//
// Optional feature macro: DECODE_DIRECT_REDIRECT_EN
//   defined   -> direct branches/JAL are target-checked against the fetch
//                prediction, and a one-cycle redirect pulse is raised.
//   undefined -> redirect_valid_o / redirect_pc_o are tied to zero.
//
// Ports (decode_uop_seq):
//   clk, rstn          clock, asynchronous active-low reset
//   in_i/_valid/_ready fetched instruction handshake (pc, data, bp)
//   di_o/_valid/_ready FIFO head uop toward rename (si, id, bqid, fault)
//   bq_push_io         branch-queue push (valid, pc, id, bp out; bqid in)
//   bq_full_i          branch queue cannot take a push
//   squash_io          flush request (valid, id of last surviving uop)
//   occupancy_o        FIFO fill level
//   redirect_valid_o   direct-branch mispredict pulse
//   redirect_pc_o      corrected target
// ---------------------------------------------------------------------------

package decode_uop_seq_pkg;
    typedef logic [31:0] pc_t;
    typedef logic [3:0]  id_t;
    typedef logic [2:0]  bqid_t;
    typedef logic [1:0]  fu_t;
    typedef logic [1:0]  size_t;

    localparam fu_t FU_ALU  = 2'd0;
    localparam fu_t FU_MUL  = 2'd1;
    localparam fu_t FU_LSU  = 2'd2;
    localparam fu_t FU_CTRL = 2'd3;

    localparam size_t SIZE_B = 2'd0;
    localparam size_t SIZE_H = 2'd1;
    localparam size_t SIZE_W = 2'd2;
    localparam size_t SIZE_D = 2'd3;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic taken;
        pc_t  pcnext;
    } bp_t;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] data;
        bp_t         bp;
    } fetch_data_t;

    typedef struct packed {
        fu_t                fu;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [4:0]         rs1;
        logic               rs1_valid;
        logic [4:0]         rs2;
        logic               rs2_valid;
        logic [4:0]         rd;
        logic               rd_valid;
        logic signed [31:0] imm;
        size_t              size;
        logic               direct;   // target = pc + imm (B-type or JAL)
        logic               is_jal;
        logic               split;    // JAL/JALR with rd != x0
        logic               illegal;
        logic [31:0]        tinst;
    } si_t;

    typedef struct packed {
        si_t   si;
        id_t   id;
        bqid_t bqid;
        logic  fault;
    } di_t;
endpackage

// Branch-queue push channel: the decode stage is the master.
interface bq_push_if;
    logic                      valid;
    decode_uop_seq_pkg::pc_t   pc;
    decode_uop_seq_pkg::id_t   id;
    decode_uop_seq_pkg::bp_t   bp;
    decode_uop_seq_pkg::bqid_t bqid;
    modport master (output valid, pc, id, bp, input bqid);
    modport slave  (input valid, pc, id, bp, output bqid);
endinterface

// Flush request: id is the youngest surviving uop.
interface squash_if;
    logic                    valid;
    decode_uop_seq_pkg::id_t id;
    modport master (output valid, id);
    modport slave  (input valid, id);
endinterface

// ---------------------------------------------------------------------------
// static_decoder: purely combinational RV decode of one 32-bit instruction.
//   instr_i  raw instruction bits
//   si_o     decoded static-instruction record
// ---------------------------------------------------------------------------
module static_decoder
    import decode_uop_seq_pkg::*;
(
    input  logic [31:0] instr_i,
    output si_t         si_o
);
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    always_comb begin
        opcode = instr_i[6:0];
        funct3 = instr_i[14:12];
        imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
        imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        imm_u  = {instr_i[31:12], 12'b0};
        imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

        si_o        = '0;
        si_o.opcode = opcode;
        si_o.funct3 = funct3;
        si_o.rs1    = instr_i[19:15];
        si_o.rs2    = instr_i[24:20];
        si_o.rd     = instr_i[11:7];
        si_o.size   = SIZE_D;
        si_o.tinst  = instr_i;
        si_o.fu     = FU_ALU;

        case (opcode)
            OPC_OP_IMM: begin
                si_o.rs1_valid = 1'b1;
                si_o.rd_valid  = 1'b1;
                si_o.imm       = imm_i;
            end
            OPC_OP: begin
                si_o.fu        = instr_i[25] ? FU_MUL : FU_ALU;
                si_o.rs1_valid = 1'b1;
                si_o.rs2_valid = 1'b1;
                si_o.rd_valid  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                si_o.rd_valid = 1'b1;
                si_o.imm      = imm_u;
            end
            OPC_LOAD: begin
                si_o.fu        = FU_LSU;
                si_o.rs1_valid = 1'b1;
                si_o.rd_valid  = 1'b1;
                si_o.imm       = imm_i;
                si_o.size      = size_t'(funct3[1:0]);
            end
            OPC_STORE: begin
                si_o.fu        = FU_LSU;
                si_o.rs1_valid = 1'b1;
                si_o.rs2_valid = 1'b1;
                si_o.imm       = imm_s;
                si_o.size      = size_t'(funct3[1:0]);
            end
            OPC_BRANCH: begin
                si_o.fu        = FU_CTRL;
                si_o.rs1_valid = 1'b1;
                si_o.rs2_valid = 1'b1;
                si_o.imm       = imm_b;
                // funct3 010/011 are unallocated branch encodings
                si_o.direct    = (funct3 != 3'b010) && (funct3 != 3'b011);
                si_o.illegal   = !si_o.direct;
            end
            OPC_JAL: begin
                si_o.fu       = FU_CTRL;
                si_o.rd_valid = 1'b1;
                si_o.imm      = imm_j;
                si_o.direct   = 1'b1;
                si_o.is_jal   = 1'b1;
            end
            OPC_JALR: begin
                si_o.fu        = FU_CTRL;
                si_o.rs1_valid = 1'b1;
                si_o.rd_valid  = 1'b1;
                si_o.imm       = imm_i;
            end
            default: si_o.illegal = 1'b1;
        endcase

        // Writes to x0 are architecturally dropped
        si_o.rd_valid = si_o.rd_valid && (si_o.rd != 5'd0);
        si_o.split    = ((opcode == OPC_JAL) || (opcode == OPC_JALR)) && (si_o.rd != 5'd0);
    end
endmodule

// ---------------------------------------------------------------------------
// dynamic_decoder_fault: fault bit for a candidate uop.
//   illegal_i   undecodable instruction
//   direct_i    direct control transfer (target = pc + imm)
//   imm_bit1_i  bit 1 of the immediate
//   fault_o     uop must raise an exception at commit
// Without compressed instructions pc is word aligned, so a direct target
// with imm[1] set is misaligned.
// ---------------------------------------------------------------------------
module dynamic_decoder_fault (
    input  logic illegal_i,
    input  logic direct_i,
    input  logic imm_bit1_i,
    output logic fault_o
);
    assign fault_o = illegal_i || (direct_i && imm_bit1_i);
endmodule

// ---------------------------------------------------------------------------
// decode_uop_seq top (see file header for port summary)
// ---------------------------------------------------------------------------
module decode_uop_seq
    import decode_uop_seq_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  fetch_data_t                    in_i,
    input  logic                           in_i_valid,
    output logic                           in_i_ready,
    output di_t                            di_o,
    output logic                           di_o_valid,
    input  logic                           di_o_ready,
    bq_push_if.master                      bq_push_io,
    input  logic                           bq_full_i,
    squash_if.slave                        squash_io,
    output logic [$clog2(OUT_DEPTH+1)-1:0] occupancy_o,
    output logic                           redirect_valid_o,
    output pc_t                            redirect_pc_o
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_UOP1 = 1'b1;

    logic [0:0]    state_q, state_d;
    id_t           id_q, id_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    di_t           mem_q [OUT_DEPTH];

    // Held split instruction (jump half), data only
    pc_t hold_pc_q, hold_pc_d;
    si_t hold_si_q, hold_si_d;
    bp_t hold_bp_q, hold_bp_d;

    si_t  dec_si, cand_si;
    pc_t  cand_pc;
    bp_t  cand_bp;
    logic cand_valid, cand_ctrl, cand_fault;
    logic full, enq, deq;
    di_t  enq_entry;

    static_decoder u_static_decoder (
        .instr_i (in_i.data),
        .si_o    (dec_si)
    );

    dynamic_decoder_fault u_fault (
        .illegal_i  (cand_si.illegal),
        .direct_i   (cand_si.direct),
        .imm_bit1_i (cand_si.imm[1]),
        .fault_o    (cand_fault)
    );

    // Candidate selection: fresh decode, the auipc half of a split, or the held jump
    always_comb begin
        cand_si    = dec_si;
        cand_pc    = in_i.pc;
        cand_bp    = in_i.bp;
        cand_valid = in_i_valid;
        if (state_q == ST_UOP1) begin
            cand_si          = hold_si_q;
            cand_si.rd       = 5'd0;
            cand_si.rd_valid = 1'b0;
            cand_si.split    = 1'b0;
            cand_si.tinst    = {hold_si_q.tinst[31:12], 5'd0, hold_si_q.tinst[6:0]};
            cand_pc          = hold_pc_q;
            cand_bp          = hold_bp_q;
            cand_valid       = 1'b1;
        end else if (dec_si.split) begin
            cand_si          = '0;
            cand_si.fu       = FU_ALU;
            cand_si.opcode   = OPC_AUIPC;
            cand_si.imm      = 32'sd4;
            cand_si.size     = SIZE_D;
            cand_si.rd       = dec_si.rd;
            cand_si.rd_valid = 1'b1;
            cand_si.tinst    = {20'd0, dec_si.rd, OPC_AUIPC};
        end
    end

    // Handshake and next-state
    always_comb begin
        full      = (count_q == CW'(OUT_DEPTH));
        cand_ctrl = (cand_si.fu == FU_CTRL);
        // rstn gates the combinational outputs so nothing leaks while held in reset
        in_i_ready = rstn && (state_q == ST_IDLE) && !squash_io.valid && !full &&
                     !((dec_si.fu == FU_CTRL) && !dec_si.split && bq_full_i);
        enq = rstn && cand_valid && !full && !squash_io.valid && !(cand_ctrl && bq_full_i);
        deq = di_o_valid && di_o_ready && !squash_io.valid;

        enq_entry       = '0;
        enq_entry.si    = cand_si;
        enq_entry.id    = id_q;
        enq_entry.bqid  = cand_ctrl ? bq_push_io.bqid : '0;
        enq_entry.fault = cand_fault;

        state_d  = state_q;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        hold_pc_d = hold_pc_q;
        hold_si_d = hold_si_q;
        hold_bp_d = hold_bp_q;
        if (enq && (state_q == ST_IDLE) && dec_si.split) begin
            hold_pc_d = in_i.pc;
            hold_si_d = dec_si;
            hold_bp_d = in_i.bp;
        end

        if (squash_io.valid) begin
            state_d  = ST_IDLE;
            id_d     = squash_io.id + id_t'(1);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                id_d     = id_q + id_t'(1);
                if (state_q == ST_UOP1)
                    state_d = ST_IDLE;
                else if (dec_si.split)
                    state_d = ST_UOP1;
            end
            if (deq)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Control state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Datapath storage: validity is carried entirely by the control state
    always_ff @(posedge clk) begin
        hold_pc_q <= hold_pc_d;
        hold_si_q <= hold_si_d;
        hold_bp_q <= hold_bp_d;
        if (enq)
            mem_q[wr_ptr_q] <= enq_entry;
    end

    assign di_o_valid  = (count_q != '0);
    assign di_o        = di_o_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy_o = count_q;

    assign bq_push_io.valid = enq && cand_ctrl;
    assign bq_push_io.pc    = cand_pc;
    assign bq_push_io.id    = id_q;
    assign bq_push_io.bp    = cand_bp;

`ifdef DECODE_DIRECT_REDIRECT_EN
    logic redirect_valid_q, redirect_valid_d;
    pc_t  redirect_pc_q, redirect_pc_d;
    pc_t  target;
    logic mispredict;

    function automatic pc_t branch_target(input pc_t pc, input logic signed [31:0] imm);
        return pc + pc_t'(imm);
    endfunction

    always_comb begin
        target     = branch_target(cand_pc, cand_si.imm);
        // An untaken-predicted JAL is always wrong; a taken prediction must match the target
        mispredict = (cand_bp.taken && (cand_bp.pcnext != target)) ||
                     (cand_si.is_jal && !cand_bp.taken);
        redirect_valid_d = enq && cand_si.direct && mispredict;
        redirect_pc_d    = redirect_valid_d ? target : redirect_pc_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
`else
    assign redirect_valid_o = 1'b0;
    assign redirect_pc_o    = '0;
`endif
endmodule

// File: tb/tb_decode_uop_seq.sv
`timescale 1ns/1ps
module tb_decode_uop_seq;
    import decode_uop_seq_pkg::*;

    localparam int OUT_DEPTH = 2;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic          clk;
    logic          rstn;
    fetch_data_t   in_i;
    logic          in_i_valid;
    logic          in_i_ready;
    di_t           di_o;
    logic          di_o_valid;
    logic          di_o_ready;
    logic          bq_full_i;
    logic [CW-1:0] occupancy_o;
    logic          redirect_valid_o;
    pc_t           redirect_pc_o;

    bq_push_if bq_if ();
    squash_if  sq_if ();

    decode_uop_seq #(.OUT_DEPTH(OUT_DEPTH)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .in_i             (in_i),
        .in_i_valid       (in_i_valid),
        .in_i_ready       (in_i_ready),
        .di_o             (di_o),
        .di_o_valid       (di_o_valid),
        .di_o_ready       (di_o_ready),
        .bq_push_io       (bq_if),
        .bq_full_i        (bq_full_i),
        .squash_io        (sq_if),
        .occupancy_o      (occupancy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int push_cnt = 0;
    int p0;
    logic [3:0] got[$];
    logic accepted;
    int k;
    logic exp_rv;
    pc_t exp_rpc;

    always @(posedge clk) if (bq_if.valid === 1'b1) push_cnt <= push_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fetch_data_t mk(input pc_t pc, input logic [31:0] data,
                                       input logic taken, input pc_t pcnext);
        fetch_data_t f;
        f.pc        = pc;
        f.data      = data;
        f.bp.taken  = taken;
        f.bp.pcnext = pcnext;
        return f;
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int imm);
        return {imm[11:0], 5'd0, 3'b000, rd[4:0], 7'b0010011};
    endfunction

    task automatic do_reset();
        rstn        = 1'b0;
        in_i_valid  = 1'b0;
        di_o_ready  = 1'b0;
        bq_full_i   = 1'b0;
        sq_if.valid = 1'b0;
        sq_if.id    = '0;
        bq_if.bqid  = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b1;
        in_i        = mk(32'h8000_0000, 32'h0050_0093, 1'b0, '0);
        in_i_valid  = 1'b1;
        di_o_ready  = 1'b1;
        bq_full_i   = 1'b0;
        sq_if.valid = 1'b0;
        sq_if.id    = '0;
        bq_if.bqid  = '0;
        #2 rstn = 1'b0;

        // Reset values with a valid instruction offered
        @(negedge clk);
        check("rst_di_vld", di_o_valid, 0);
        check("rst_di", di_o, 0);
        check("rst_in_rdy", in_i_ready, 0);
        check("rst_bq_vld", bq_if.valid, 0);
        check("rst_occ", occupancy_o, 0);
        check("rst_redir_vld", redirect_valid_o, 0);
        check("rst_redir_pc", redirect_pc_o, 0);

        // ADDI x1,x0,5
        do_reset();
        di_o_ready = 1'b1;
        in_i       = mk(32'h8000_0000, 32'h0050_0093, 1'b0, '0);
        in_i_valid = 1'b1;
        p0 = push_cnt;
        @(negedge clk);
        check("addi_rdy", in_i_ready, 1);
        check("addi_nopush", bq_if.valid, 0);
        tick();
        in_i_valid = 1'b0;
        check("addi_vld", di_o_valid, 1);
        check("addi_id", di_o.id, 0);
        check("addi_rd", di_o.si.rd, 1);
        check("addi_imm", di_o.si.imm, 5);
        check("addi_fu", di_o.si.fu, FU_ALU);
        check("addi_fault", di_o.fault, 0);
        check("addi_bqid", di_o.bqid, 0);
        tick();
        check("addi_drain", di_o_valid, 0);
        check("addi_pushes", push_cnt - p0, 0);

        // JAL x1,+0x100 at 0x1000 -> auipc + jump
        do_reset();
        di_o_ready = 1'b1;
        bq_if.bqid = 3'd5;
        in_i       = mk(32'h1000, 32'h1000_00EF, 1'b1, 32'h1100);
        in_i_valid = 1'b1;
        p0 = push_cnt;
        @(negedge clk);
        check("jal_rdy0", in_i_ready, 1);
        check("jal_nopush0", bq_if.valid, 0);
        tick();
        in_i_valid = 1'b0;
        check("jal_u0_vld", di_o_valid, 1);
        check("jal_u0_id", di_o.id, 0);
        check("jal_u0_rd", di_o.si.rd, 1);
        check("jal_u0_imm", di_o.si.imm, 4);
        check("jal_u0_fu", di_o.si.fu, FU_ALU);
        check("jal_u0_opc", di_o.si.opcode, 7'h17);
        @(negedge clk);
        check("jal_busy_rdy", in_i_ready, 0);
        check("jal_push_vld", bq_if.valid, 1);
        check("jal_push_pc", bq_if.pc, 32'h1000);
        check("jal_push_id", bq_if.id, 1);
        tick();
        check("jal_u1_vld", di_o_valid, 1);
        check("jal_u1_id", di_o.id, 1);
        check("jal_u1_rd", di_o.si.rd, 0);
        check("jal_u1_rdv", di_o.si.rd_valid, 0);
        check("jal_u1_fu", di_o.si.fu, FU_CTRL);
        check("jal_u1_bqid", di_o.bqid, 5);
        check("jal_u1_imm", di_o.si.imm, 32'h100);
        check("jal_u1_tinst", di_o.si.tinst, 32'h1000_006F);
        check("jal_rdy_back", in_i_ready, 1);
        check("jal_pushes", push_cnt - p0, 1);
        tick();
        check("jal_drain", di_o_valid, 0);

        // BEQ stalled by a full branch queue for three cycles
        do_reset();
        di_o_ready = 1'b1;
        bq_full_i  = 1'b1;
        bq_if.bqid = 3'd2;
        in_i       = mk(32'h3000, 32'h0000_0463, 1'b0, '0);
        in_i_valid = 1'b1;
        p0 = push_cnt;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("beq_stall_rdy", in_i_ready, 0);
            check("beq_stall_push", bq_if.valid, 0);
            tick();
            check("beq_stall_empty", di_o_valid, 0);
        end
        bq_full_i = 1'b0;
        @(negedge clk);
        check("beq_go_rdy", in_i_ready, 1);
        check("beq_go_push", bq_if.valid, 1);
        check("beq_go_id", bq_if.id, 0);
        check("beq_go_pc", bq_if.pc, 32'h3000);
        tick();
        in_i_valid = 1'b0;
        check("beq_vld", di_o_valid, 1);
        check("beq_fu", di_o.si.fu, FU_CTRL);
        check("beq_bqid", di_o.bqid, 2);
        check("beq_imm", di_o.si.imm, 8);
        check("beq_pushes", push_cnt - p0, 1);

        // Fill the FIFO with four ALU ops, then release
        do_reset();
        got.delete();
        k = 0;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            in_i       = mk(32'h4000 + 32'(4 * k), enc_addi(k + 1, k), 1'b0, '0);
            in_i_valid = (k < 4);
            di_o_ready = (c >= 5);
            @(negedge clk);
            if (c == 4) begin
                check("fill_occ", occupancy_o, 2);
                check("fill_rdy", in_i_ready, 0);
                check("fill_vld", di_o_valid, 1);
            end
            if (di_o_valid && di_o_ready) got.push_back(di_o.id);
            accepted = in_i_valid && in_i_ready;
            tick();
            if (accepted) k++;
        end
        in_i_valid = 1'b0;
        check("fill_count", got.size(), 4);
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) check("fill_id", got[i], i);

        // Squash while the jump half of a split is pending
        do_reset();
        di_o_ready = 1'b0;
        in_i       = mk(32'h1000, 32'h1000_00EF, 1'b1, 32'h1100);
        in_i_valid = 1'b1;
        tick();
        in_i_valid  = 1'b0;
        sq_if.valid = 1'b1;
        sq_if.id    = 4'd7;
        p0 = push_cnt;
        @(negedge clk);
        check("sq_nopush", bq_if.valid, 0);
        check("sq_rdy", in_i_ready, 0);
        check("sq_vld_before", di_o_valid, 1);
        tick();
        sq_if.valid = 1'b0;
        check("sq_empty", di_o_valid, 0);
        check("sq_occ", occupancy_o, 0);
        @(negedge clk);
        check("sq_idle_rdy", in_i_ready, 1);
        check("sq_no_jump", bq_if.valid, 0);
        tick();
        check("sq_dropped", di_o_valid, 0);
        check("sq_pushes", push_cnt - p0, 0);
        in_i       = mk(32'h5000, 32'h0050_0093, 1'b0, '0);
        in_i_valid = 1'b1;
        tick();
        in_i_valid = 1'b0;
        check("sq_next_vld", di_o_valid, 1);
        check("sq_next_id", di_o.id, 8);
        check("sq_next_rd", di_o.si.rd, 1);

        // Squash with id 15: counter wraps to 0, pop in the same cycle ignored
        di_o_ready  = 1'b1;
        sq_if.valid = 1'b1;
        sq_if.id    = 4'hF;
        tick();
        sq_if.valid = 1'b0;
        di_o_ready  = 1'b0;
        check("wrap_empty", di_o_valid, 0);
        in_i_valid = 1'b1;
        tick();
        in_i_valid = 1'b0;
        check("wrap_id", di_o.id, 0);
        check("wrap_occ", occupancy_o, 1);

        // BNE +0x20 at 0x2000, predicted taken to 0x2040
        do_reset();
        di_o_ready = 1'b1;
        bq_if.bqid = 3'd1;
        in_i       = mk(32'h2000, 32'h0200_1063, 1'b1, 32'h2040);
        in_i_valid = 1'b1;
`ifdef DECODE_DIRECT_REDIRECT_EN
        exp_rv  = 1'b1;
        exp_rpc = 32'h2020;
`else
        exp_rv  = 1'b0;
        exp_rpc = 32'h0;
`endif
        @(negedge clk);
        check("bne_pre_redir", redirect_valid_o, 0);
        tick();
        in_i_valid = 1'b0;
        check("bne_imm", di_o.si.imm, 32'h20);
        check("bne_redir_vld", redirect_valid_o, exp_rv);
        check("bne_redir_pc", redirect_pc_o, exp_rpc);
        tick();
        check("bne_redir_pulse", redirect_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_uop_seq.md
# decode_uop_seq

Parametrised decode stage with a micro-op sequencer and a buffered output. Sits between fetch and rename. Each fetched instruction is statically decoded and expanded into one or two uops: JAL/JALR with rd≠x0 becomes `auipc rd, 4` followed by the jump with rd=x0. Uops are tagged with a sequential instruction id, pushed to the branch queue when they are control uops, and buffered in an OUT_DEPTH-entry FIFO toward rename. The stage honours branch-queue backpressure and squash.

## Interface
- OUT_DEPTH, 2, output FIFO entries; power of two, ≥2.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_i  in  fetch_data_t  fetched instruction: pc, data, bp.
- in_i_valid  in  1  in_i is valid.
- in_i_ready  out  1  stage accepts in_i this cycle.
- di_o  out  di_t  FIFO head uop: si, id, bqid, fault.
- di_o_valid  out  1  FIFO not empty.
- di_o_ready  in  1  rename pops the head.
- bq_push_io  bq_push_if.master  —  branch-queue push: valid, pc, id, bp in; bqid back.
- bq_full_i  in  1  branch queue cannot accept a push.
- squash_io  squash_if.slave  —  flush request: valid, id.
- occupancy_o  out  $clog2(OUT_DEPTH+1)  FIFO fill level.
- redirect_valid_o  out  1  direct-branch mispredict detected.
- redirect_pc_o  out  pc_t  corrected target.

## Operation
- The stage instantiates `static_decoder` and `dynamic_decoder_fault`. The fault bit is computed on the candidate uop and stored with the entry.
- **Sequencer FSM:**
  - IDLE: candidate = decoded in_i.
  - UOP1: candidate = held jump with rd/rd_valid cleared and tinst.rd=0.
  - IDLE→UOP1 when a split instruction enqueues uop0. Uop0 is the auipc: FU_ALU, imm=4, SIZE_D, rd=decoded rd.
  - UOP1→IDLE when the jump enqueues.
- **Input hold:** in_i is consumed on the uop0 enqueue. Pc, si and bp are captured into a hold register.
- **in_i_ready** = rstn && state==IDLE && !squash && FIFO not full && !(decoded is FU_CTRL, unsplit, and bq_full_i).
- **enq** = candidate valid && FIFO not full && !squash && !(candidate is FU_CTRL && bq_full_i).
- **On enq:**
  - id = id counter; counter increments by 1 and wraps at id_t width.
  - If FU_CTRL: bq_push_io.valid=1 with the uop's pc, id and bp; entry bqid = bq_push_io.bqid. Otherwise bqid=0.
- **Dequeue:** when di_o_valid && di_o_ready. Enqueue and dequeue may occur in the same cycle, but enqueue requires not-full at cycle start (no full-bypass).
- **Squash (squash_io.valid):**
  - FIFO cleared and FSM→IDLE.
  - Id counter ← squash_io.id+1.
  - No enqueue, no BQ push, no redirect that cycle.
- **Reset values (rstn low):** all outputs as follows — di_o_valid=0, di_o=0, in_i_ready=0, bq_push_io.valid=0, occupancy_o=0, redirect_valid_o=0, redirect_pc_o=0. Internal state: id counter=0, FSM=IDLE, FIFO empty. Reset mid-sequence (in UOP1) discards the held jump.

## Timing
- Latency: in_i accepted in cycle N → di_o_valid in N+1.
- Split instruction: auipc enqueues in N, jump in N+1, in_i_ready=0 in N+1. Both appear at the head in consecutive cycles if popped.
- Throughput: 1 uop/cycle while di_o_ready=1.
- bq_push_io.valid is combinational in the enqueue cycle, exactly once per control uop. bq_full_i stalls without dropping the uop.
- Full FIFO: in_i_ready=0 and the candidate is held. Empty FIFO: di_o_valid=0.
- Squash and di_o_ready in the same cycle: the squash wins and no pop is counted.

## Configuration
- DECODE_DIRECT_REDIRECT_EN defined: for an enqueued direct branch (BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL), target = pc + imm, computed mod 2^|pc_t|.
  - Redirect fires if bp.taken && bp.pcnext≠target, or if JAL && !bp.taken.
  - redirect_valid_o pulses in the cycle after enqueue; redirect_pc_o=target.
- Macro undefined: redirect_valid_o and redirect_pc_o are tied to 0 and no target adder is built.

## Test plan
- **ADDI x1,x0,5 at pc 0x80000000, di_o_ready=1:** in_i accepted in N → di_o_valid in N+1 with id=0, rd=x1, no BQ push.
- **JAL x1,+0x100 at 0x1000:**
  - Uop0 auipc x1 imm=4 enqueues with id 0; jump rd=x0 id 1 follows.
  - One BQ push with pc 0x1000, id 1.
  - in_i_ready=0 for one cycle.
- **BEQ with bq_full_i=1 for 3 cycles:** in_i_ready=0 and no enqueue for those cycles → enqueue plus a single push in cycle 4.
- **Fill:** di_o_ready=0 with 4 ALU ops, OUT_DEPTH=2 → occupancy_o=2, in_i_ready=0. Release → ids 0,1,2,3 in order.
- **Squash during UOP1 with squash_io.id=7:** FIFO empties, the held jump is dropped, and the next enqueued uop has id 8.
- **DECODE_DIRECT_REDIRECT_EN, BNE imm=+0x20 at 0x2000, bp.taken=1, pcnext=0x2040:** redirect_valid_o=1 for one cycle with redirect_pc_o=0x2020.
